// File: rtl/ysyx_22040632_icache.sv
// rtl/ysyx_22040632_icache.sv - direct-mapped instruction cache with AXI4 read refill and uncached bypass
module ysyx_22040632_icache #(
  parameter int SETS   = 16,
  parameter int LINE_W = 128,
  parameter int AXI_DW = 64
) (
  input  logic                clk,
  input  logic                rrst_n,
  input  logic                fence_i,
  input  logic                ic_valid,
  input  logic [31:0]         ic_pc,
  input  logic                ic_uncache,
  output logic                ic_ready,
  output logic [LINE_W-1:0]   ic_inst,
  output logic                arvalid,
  input  logic                arready,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [AXI_DW-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 4 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_AR,
    S_R,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e              state_q;
  logic [31:0]         req_pc_q;
  logic                req_unc_q;
  logic [SETS-1:0]     valid_q;
  logic                arvalid_q;
  logic [31:0]         araddr_q;
  logic                rready_q;
  logic                ready_q;
  logic [LINE_W-1:0]   inst_q;
  logic                beat_q;
  logic                err_q;
  logic                fence_pend_q;

  // Tag and data storage carry no reset; the valid bits alone qualify them.
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [LINE_W-1:0]   data_q [SETS];

  logic [IDX_W-1:0]    req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                hit;
  logic                req_match;
  logic                r_fire;
  logic                rd_ok;
  logic                install;

  // Request decode, hit detection and refill-install qualification.
  always_comb begin
    req_idx   = req_pc_q[4 +: IDX_W];
    req_tag   = req_pc_q[31 -: TAG_W];
    hit       = ~req_unc_q & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    req_match = ic_valid & (ic_pc == req_pc_q);
    r_fire    = rready_q & rvalid;
    rd_ok     = (rresp == 2'b00);
    // A fence on the final beat wins over the install so the line stays invalid.
    install   = (state_q == S_R) & r_fire & rlast & ~req_unc_q & ~err_q & rd_ok & ~fence_i;
  end

  // Control FSM with registered handshake outputs, valid bits and response line.
  always_ff @(posedge clk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= S_IDLE;
      req_pc_q     <= '0;
      req_unc_q    <= 1'b0;
      valid_q      <= '0;
      arvalid_q    <= 1'b0;
      araddr_q     <= '0;
      rready_q     <= 1'b0;
      ready_q      <= 1'b0;
      inst_q       <= '0;
      beat_q       <= 1'b0;
      err_q        <= 1'b0;
      fence_pend_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;

      if (fence_i) begin
        valid_q <= '0;
      end else if (install) begin
        valid_q[req_idx] <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (ic_valid) begin
            req_pc_q  <= ic_pc;
            req_unc_q <= ic_uncache;
            state_q   <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (fence_i) begin
            state_q <= S_IDLE;
          end else if (hit) begin
            inst_q  <= data_q[req_idx];
            ready_q <= req_match;
            state_q <= S_RESP;
          end else begin
            arvalid_q    <= 1'b1;
            araddr_q     <= req_unc_q ? req_pc_q : {req_pc_q[31:4], 4'b0000};
            fence_pend_q <= 1'b0;
            state_q      <= S_AR;
          end
        end

        S_AR: begin
          // The address phase is never withdrawn; a fence is remembered and
          // turns the data phase into a drain.
          if (fence_i) begin
            fence_pend_q <= 1'b1;
          end
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= (fence_pend_q | fence_i) ? S_DRAIN : S_R;
          end
        end

        S_R: begin
          if (r_fire && !fence_i) begin
            if (req_unc_q) begin
              inst_q <= {{(LINE_W-AXI_DW){1'b0}}, rdata};
            end else if (!beat_q) begin
              inst_q[AXI_DW-1:0] <= rdata;
            end else begin
              inst_q[LINE_W-1:AXI_DW] <= rdata;
            end
          end
          if (r_fire) begin
            beat_q <= 1'b1;
            err_q  <= err_q | ~rd_ok;
          end
          if (r_fire && rlast) begin
            rready_q <= 1'b0;
            if (fence_i) begin
              state_q <= S_IDLE;
            end else begin
              ready_q <= req_match;
              state_q <= S_RESP;
            end
          end else if (fence_i) begin
            state_q <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (r_fire && rlast) begin
            rready_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Line install on a clean cacheable refill; upper beat comes straight off the bus.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= {rdata, inst_q[AXI_DW-1:0]};
    end
  end

  assign ic_ready = ready_q;
  assign ic_inst  = inst_q;
  assign arvalid  = arvalid_q;
  assign araddr   = araddr_q;
  assign arlen    = req_unc_q ? 8'd0 : 8'd1;
  assign arsize   = req_unc_q ? 3'b010 : 3'b011;
  assign arburst  = 2'b01;
  assign rready   = rready_q;

endmodule

// File: tb/tb_ysyx_22040632_icache.sv
// tb/tb_ysyx_22040632_icache.sv - directed self-checking bench for the instruction cache
module tb_ysyx_22040632_icache;

  logic         clk = 1'b0;
  logic         rrst_n = 1'b0;
  logic         fence_i = 1'b0;
  logic         ic_valid = 1'b0;
  logic [31:0]  ic_pc = '0;
  logic         ic_uncache = 1'b0;
  logic         ic_ready;
  logic [127:0] ic_inst;
  logic         arvalid;
  logic         arready = 1'b1;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [63:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;

  int total = 0;
  int bad = 0;

  // observations of the most recent fetch
  int           ar_cnt, rdy_cnt, lat, beats;
  logic [31:0]  o_addr;
  logic [7:0]   o_len;
  logic [2:0]   o_size;
  logic [1:0]   o_burst;
  logic [127:0] o_inst;

  localparam logic [63:0] A = 64'hAAAA_0000_1111_0001;
  localparam logic [63:0] B = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] C = 64'hCCCC_0000_3333_0003;
  localparam logic [63:0] D = 64'hDDDD_0000_4444_0004;
  localparam logic [63:0] E = 64'hEEEE_0000_5555_0005;
  localparam logic [63:0] F = 64'hFFFF_0000_6666_0006;
  localparam logic [63:0] G = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] H = 64'h0FED_CBA9_8765_4321;

  always #5 clk = ~clk;

  ysyx_22040632_icache dut (
    .clk(clk), .rrst_n(rrst_n), .fence_i(fence_i),
    .ic_valid(ic_valid), .ic_pc(ic_pc), .ic_uncache(ic_uncache),
    .ic_ready(ic_ready), .ic_inst(ic_inst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  // Acts as IFU plus AXI slave for one fetch and records what the cache did.
  task automatic fetch(input logic [31:0] pc, input logic unc, input int nb,
                       input logic [63:0] b0, input logic [63:0] b1,
                       input logic [1:0] resp1, input int fence_beat);
    int beat;
    logic rready_prev;
    ar_cnt = 0; rdy_cnt = 0; lat = -1; beats = 0; o_inst = '0;
    o_addr = '0; o_len = '0; o_size = '0; o_burst = '0;
    beat = 0; rready_prev = 1'b0;
    ic_pc = pc; ic_uncache = unc; ic_valid = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      fence_i = 1'b0;
      if (rvalid && rready_prev) beat++;
      if (arvalid) begin
        ar_cnt++; o_addr = araddr; o_len = arlen; o_size = arsize; o_burst = arburst;
      end
      if (ic_ready) begin
        rdy_cnt++;
        if (lat < 0) lat = cyc;
        o_inst = ic_inst;
        ic_valid = 1'b0;
      end
      if (rready && beat < nb) begin
        rvalid = 1'b1;
        rdata  = (beat == 0) ? b0 : b1;
        rlast  = (beat == nb - 1);
        rresp  = (beat == 1) ? resp1 : 2'b00;
        if (beat == fence_beat) fence_i = 1'b1;
      end else begin
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
      rready_prev = rready;
      if (lat >= 0 || (nb > 0 && beat == nb && !rready)) break;
    end
    ic_valid = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; fence_i = 1'b0;
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      if (ic_ready) rdy_cnt++;
      if (arvalid) ar_cnt++;
    end
    beats = beat;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (ic_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ic_ready); end
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL reset_arvalid got=%b want=0", arvalid); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL reset_rready got=%b want=0", rready); end
    total++; if (ic_inst !== 128'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", ic_inst); end
    rrst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL idle_arvalid got=%b want=0", arvalid); end
  endtask

  task automatic test_cold_miss();
    fetch(32'h8000_0000, 1'b0, 2, A, B, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL cold_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_addr !== 32'h8000_0000) begin bad++; $display("FAIL cold_araddr got=%h want=80000000", o_addr); end
    total++; if (o_len !== 8'd1) begin bad++; $display("FAIL cold_arlen got=%0d want=1", o_len); end
    total++; if (o_size !== 3'b011) begin bad++; $display("FAIL cold_arsize got=%b want=011", o_size); end
    total++; if (o_burst !== 2'b01) begin bad++; $display("FAIL cold_arburst got=%b want=01", o_burst); end
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL cold_ready_cnt got=%0d want=1", rdy_cnt); end
    total++; if (lat !== 5) begin bad++; $display("FAIL cold_latency got=%0d want=5", lat); end
    total++; if (o_inst !== {B, A}) begin bad++; $display("FAIL cold_inst got=%h want=%h", o_inst, {B, A}); end
    total++; if (ic_inst !== {B, A}) begin bad++; $display("FAIL cold_inst_held got=%h want=%h", ic_inst, {B, A}); end
  endtask

  task automatic test_hit();
    fetch(32'h8000_0004, 1'b0, 2, C, D, 2'b00, -1);
    total++; if (ar_cnt !== 0) begin bad++; $display("FAIL hit_ar_cnt got=%0d want=0", ar_cnt); end
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL hit_ready_cnt got=%0d want=1", rdy_cnt); end
    total++; if (lat !== 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
    total++; if (o_inst !== {B, A}) begin bad++; $display("FAIL hit_inst got=%h want=%h", o_inst, {B, A}); end
  endtask

  task automatic test_alias();
    fetch(32'h8000_0100, 1'b0, 2, C, D, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL alias_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_addr !== 32'h8000_0100) begin bad++; $display("FAIL alias_araddr got=%h want=80000100", o_addr); end
    total++; if (o_inst !== {D, C}) begin bad++; $display("FAIL alias_inst got=%h want=%h", o_inst, {D, C}); end
    fetch(32'h8000_0000, 1'b0, 2, E, F, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL alias_back_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_inst !== {F, E}) begin bad++; $display("FAIL alias_back_inst got=%h want=%h", o_inst, {F, E}); end
    fetch(32'h8000_000C, 1'b0, 2, A, B, 2'b00, -1);
    total++; if (ar_cnt !== 0) begin bad++; $display("FAIL alias_rehit_ar_cnt got=%0d want=0", ar_cnt); end
    total++; if (o_inst !== {F, E}) begin bad++; $display("FAIL alias_rehit_inst got=%h want=%h", o_inst, {F, E}); end
  endtask

  task automatic test_uncache();
    fetch(32'hA000_0004, 1'b1, 1, G, 64'h0, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL unc_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_addr !== 32'hA000_0004) begin bad++; $display("FAIL unc_araddr got=%h want=a0000004", o_addr); end
    total++; if (o_len !== 8'd0) begin bad++; $display("FAIL unc_arlen got=%0d want=0", o_len); end
    total++; if (o_size !== 3'b010) begin bad++; $display("FAIL unc_arsize got=%b want=010", o_size); end
    total++; if (lat !== 4) begin bad++; $display("FAIL unc_latency got=%0d want=4", lat); end
    total++; if (o_inst !== {64'h0, G}) begin bad++; $display("FAIL unc_inst got=%h want=%h", o_inst, {64'h0, G}); end
    fetch(32'hA000_0004, 1'b1, 1, H, 64'h0, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL unc2_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_inst !== {64'h0, H}) begin bad++; $display("FAIL unc2_inst got=%h want=%h", o_inst, {64'h0, H}); end
  endtask

  task automatic test_fence_refill();
    fetch(32'h8000_0020, 1'b0, 2, A, B, 2'b00, 0);
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL fence_ready_cnt got=%0d want=0", rdy_cnt); end
    total++; if (beats !== 2) begin bad++; $display("FAIL fence_beats got=%0d want=2", beats); end
    total++; if (rready !== 1'b0) begin bad++; $display("FAIL fence_rready_after got=%b want=0", rready); end
    fetch(32'h8000_0020, 1'b0, 2, C, D, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL fence_refetch_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_inst !== {D, C}) begin bad++; $display("FAIL fence_refetch_inst got=%h want=%h", o_inst, {D, C}); end
  endtask

  task automatic test_fence_idle();
    fence_i = 1'b1;
    @(posedge clk); #1;
    fence_i = 1'b0;
    fetch(32'h8000_0004, 1'b0, 2, G, H, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL fenceidle_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_inst !== {H, G}) begin bad++; $display("FAIL fenceidle_inst got=%h want=%h", o_inst, {H, G}); end
  endtask

  task automatic test_slverr();
    fetch(32'h8000_0040, 1'b0, 2, E, F, 2'b10, -1);
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL slverr_ready_cnt got=%0d want=1", rdy_cnt); end
    total++; if (o_inst !== {F, E}) begin bad++; $display("FAIL slverr_inst got=%h want=%h", o_inst, {F, E}); end
    fetch(32'h8000_0048, 1'b0, 2, A, B, 2'b00, -1);
    total++; if (ar_cnt !== 1) begin bad++; $display("FAIL slverr_refetch_ar_cnt got=%0d want=1", ar_cnt); end
    total++; if (o_addr !== 32'h8000_0040) begin bad++; $display("FAIL slverr_refetch_addr got=%h want=80000040", o_addr); end
    total++; if (o_inst !== {B, A}) begin bad++; $display("FAIL slverr_refetch_inst got=%h want=%h", o_inst, {B, A}); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_alias();
    test_uncache();
    test_fence_refill();
    test_fence_idle();
    test_slverr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
